swerv_trace_buf: RTL
====================

# swerv_trace_buf

Parametrised retire-trace buffer for the SweRV core complex. Each cycle it accepts one multi-lane retire trace packet with up to NUM_LANES retired instructions. Packets are queued in a DEPTH-entry FIFO and drained as one instruction record per handshake onto a narrow trace port, lowest lane first. Overflow is counted and flagged in-band; packets are never partially stored.

## Interface
- NUM_LANES, 3: retire lanes per packet (1..4)
- DEPTH, 8: FIFO entries; power of two, ≥2
- DROP_W, 16: width of saturating drop counter
- TS_W, 32: timestamp width (used only with RV_TRACE_TIMESTAMP_EN)
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  NUM_LANES  per-lane retire valid
- in_insn  in  32*NUM_LANES  instruction words, lane i at [32i+31:32i]
- in_addr  in  32*NUM_LANES  instruction addresses, same packing
- in_exception  in  NUM_LANES  per-lane exception
- in_interrupt  in  NUM_LANES  per-lane interrupt
- in_ecause  in  5  cause, shared by packet
- in_tval  in  32  trap value, shared by packet
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_lane  out  2  lane index of record
- out_insn / out_addr  out  32 / 32  record instruction / address
- out_exception / out_interrupt  out  1 / 1  record trap flags
- out_ecause / out_tval  out  5 / 32  valid only when a trap flag is set, else 0
- out_ovf  out  1  packets were dropped immediately before this record's packet
- out_ts  out  TS_W  push timestamp (only with RV_TRACE_TIMESTAMP_EN)
- drop_cnt  out  DROP_W  dropped-packet count, saturating
- full / empty  out  1 / 1  FIFO status

## Operation
- Push: a cycle with |in_valid is a push candidate. Idle cycles (in_valid==0) are ignored.
  - Stored whole if count<DEPTH, or if count==DEPTH and the head entry pops this same cycle.
  - Otherwise dropped: drop_cnt+1 (holds at all-ones) and ovf_pending set.
- Entry contents: lane mask, all lane fields, ecause, tval, ovf tag (=ovf_pending at push), optional timestamp. A successful push clears ovf_pending.
- Drain: a residual mask per head entry holds the lanes not yet sent.
  - The output selects the lowest set bit. out_lane is its index; fields come from that lane.
  - out_valid = !empty.
  - On out_valid&&out_ready, the selected bit is cleared. When the last bit clears, the entry pops and the residual mask reloads from the next entry.
- out_ovf is asserted only on the first record of an ovf-tagged entry.
- out_ecause/out_tval are driven from the entry when out_exception|out_interrupt, else 0.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = count==DEPTH; empty = count==0.

## Timing
- Reset (async assert, sync to clk on release): pointers, count, residual mask, ovf_pending, drop_cnt and timestamp all 0.
  - Outputs: out_valid=0, empty=1, full=0; all data outputs 0.
- Latency: a packet pushed at edge N is presented on out_* after edge N (cycle N+1). There is no input-to-output combinational bypass.
- Output fields are stable while out_valid&&!out_ready.
- Throughput: one record per cycle. A k-lane packet occupies the head for k accepted cycles.
- Simultaneous push and pop at full: the push succeeds and count is unchanged.
- Simultaneous push and pop at count==1 (last lane accepted): the new entry becomes head next cycle with no bubble.
- Reset mid-drain discards all entries, including partially sent ones.

## Configuration
- RV_TRACE_TIMESTAMP_EN defined:
  - A free-running TS_W counter, reset to 0, wraps at 2^TS_W.
  - Its value is captured into each entry at push and presented on out_ts for every record of that entry.
- RV_TRACE_TIMESTAMP_EN undefined: the counter and storage are absent and out_ts is tied to 0.

## Test plan
- One lane: in_valid=3'b010, addr1=0x80000004 → next cycle out_valid=1, out_lane=1, out_addr=0x80000004. Pop with ready → empty=1.
- Three lanes (valid=3'b111), out_ready=1 → three records in lane order 0,1,2 on consecutive cycles, then empty.
- Lane 2 only, exception=3'b100, ecause=5'd2, tval=0xDEADBEEF → out_exception=1, ecause=2, tval=0xDEADBEEF.
  - A following trap-free record shows ecause=0, tval=0.
- out_ready=0, push DEPTH+3 packets → full=1 and drop_cnt=3.
  - Release ready → the first record of the (DEPTH+1)-th stored packet shows out_ovf=1; all others show 0.
- At full, push while the last lane of the head is accepted → push stored, full stays 1, drop_cnt unchanged.
- Assert rst mid-drain of a 3-lane packet → out_valid=0, empty=1, drop_cnt=0 immediately.
  - With the macro: out_ts of the first push after release = cycles elapsed since reset release.

Source files
------------

// File: rtl/swerv_trace_buf.sv
// Retire-trace buffer: queues multi-lane retire packets and drains them one instruction per handshake.
// Optional per-entry push timestamps are enabled by defining RV_TRACE_TIMESTAMP_EN.
module swerv_trace_buf #(
  parameter int NUM_LANES = 3,
  parameter int DEPTH     = 8,
  parameter int DROP_W    = 16,
  parameter int TS_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LANES-1:0]   in_valid,
  input  logic [32*NUM_LANES-1:0] in_insn,
  input  logic [32*NUM_LANES-1:0] in_addr,
  input  logic [NUM_LANES-1:0]   in_exception,
  input  logic [NUM_LANES-1:0]   in_interrupt,
  input  logic [4:0]             in_ecause,
  input  logic [31:0]            in_tval,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_lane,
  output logic [31:0]            out_insn,
  output logic [31:0]            out_addr,
  output logic                   out_exception,
  output logic                   out_interrupt,
  output logic [4:0]             out_ecause,
  output logic [31:0]            out_tval,
  output logic                   out_ovf,
  output logic [TS_W-1:0]        out_ts,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [NUM_LANES-1:0]  sent_q, sent_d;
  logic                  ovf_pending_q, ovf_pending_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [NUM_LANES-1:0]   mask_mem   [DEPTH];
  logic [32*NUM_LANES-1:0] insn_mem  [DEPTH];
  logic [32*NUM_LANES-1:0] addr_mem  [DEPTH];
  logic [NUM_LANES-1:0]   exc_mem    [DEPTH];
  logic [NUM_LANES-1:0]   int_mem    [DEPTH];
  logic [4:0]             ecause_mem [DEPTH];
  logic [31:0]            tval_mem   [DEPTH];
  logic                   ovf_mem    [DEPTH];

  logic [AW-1:0]         wr_idx, rd_idx;
  logic [NUM_LANES-1:0]  residual, sel_bit;
  logic [1:0]            sel_lane;
  logic                  last_lane, accept, pop, push_req, push_ok;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign drop_cnt = drop_cnt_q;

  // Lanes of the head entry that still have to be sent; the lowest one goes out next.
  assign residual = mask_mem[rd_idx] & ~sent_q;

  always_comb begin
    sel_lane = '0;
    sel_bit  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (residual[i]) begin
        sel_lane   = 2'(i);
        sel_bit    = '0;
        sel_bit[i] = 1'b1;
      end
    end
  end

  assign last_lane = ((residual & ~sel_bit) == '0);
  assign accept    = out_valid && out_ready;
  assign pop       = accept && last_lane;
  assign push_req  = |in_valid;
  assign push_ok   = push_req && (!full || pop);

  always_comb begin
    wr_ptr_d      = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
    sent_d        = sent_q;
    ovf_pending_d = ovf_pending_q;
    drop_cnt_d    = drop_cnt_q;
    if (pop) begin
      sent_d = '0;
    end else if (accept) begin
      sent_d = sent_q | sel_bit;
    end
    if (push_ok) begin
      ovf_pending_d = 1'b0;
    end else if (push_req) begin
      ovf_pending_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sent_q        <= '0;
      ovf_pending_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sent_q        <= sent_d;
      ovf_pending_q <= ovf_pending_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Entry storage carries no reset; only slots behind the valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mask_mem[wr_idx]   <= in_valid;
      insn_mem[wr_idx]   <= in_insn;
      addr_mem[wr_idx]   <= in_addr;
      exc_mem[wr_idx]    <= in_exception;
      int_mem[wr_idx]    <= in_interrupt;
      ecause_mem[wr_idx] <= in_ecause;
      tval_mem[wr_idx]   <= in_tval;
      ovf_mem[wr_idx]    <= ovf_pending_q;
    end
  end

  always_comb begin
    out_valid     = !empty;
    out_lane      = '0;
    out_insn      = '0;
    out_addr      = '0;
    out_exception = 1'b0;
    out_interrupt = 1'b0;
    out_ecause    = '0;
    out_tval      = '0;
    out_ovf       = 1'b0;
    if (!empty) begin
      out_lane = sel_lane;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sel_bit[i]) begin
          out_insn      = insn_mem[rd_idx][32*i +: 32];
          out_addr      = addr_mem[rd_idx][32*i +: 32];
          out_exception = exc_mem[rd_idx][i];
          out_interrupt = int_mem[rd_idx][i];
          if (exc_mem[rd_idx][i] || int_mem[rd_idx][i]) begin
            out_ecause = ecause_mem[rd_idx];
            out_tval   = tval_mem[rd_idx];
          end
        end
      end
      out_ovf = ovf_mem[rd_idx] && (sent_q == '0);
    end
  end

`ifdef RV_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      ts_mem[wr_idx] <= ts_q;
    end
  end

  assign out_ts = empty ? '0 : ts_mem[rd_idx];
`else
  assign out_ts = '0;
`endif

endmodule
